// File: rtl/multi_clock_gen.sv
// Multi-channel clock/strobe generator: each channel divides CLOCK_50 by a programmable
// period with programmable high time, and changes only take effect at period boundaries.
module multi_clock_gen #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 12
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic                    sync,
    input  logic [NUM_CH*DIV_W-1:0] period,
    input  logic [NUM_CH*DIV_W-1:0] high,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       active
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_t;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DIV_W-1:0] per_in;
        logic [DIV_W-1:0] high_in;
        logic [DIV_W-1:0] p_eff;
        logic [DIV_W-1:0] h_eff;
        logic [DIV_W-1:0] cnt_inc;
        logic             last_cnt;
        logic             restart;

        ch_state_t        state_q, state_d;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] ps_q, ps_d;
        logic [DIV_W-1:0] hs_q, hs_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;

        assign per_in  = period[c*DIV_W +: DIV_W];
        assign high_in = high[c*DIV_W +: DIV_W];

        // Legalised config: period of at least 2, high time in [1, P_eff-1], 0 meaning 50%.
        always_comb begin
            p_eff = (per_in < DIV_W'(2)) ? DIV_W'(2) : per_in;
            if (high_in == '0) begin
                h_eff = p_eff >> 1;
            end else if (high_in >= p_eff) begin
                h_eff = p_eff - DIV_W'(1);
            end else begin
                h_eff = high_in;
            end
        end

        assign last_cnt = (cnt_q == ps_q - DIV_W'(1));
        assign cnt_inc  = cnt_q + DIV_W'(1);
        assign restart  = (state_q == ST_IDLE) ? en[c] : (sync || (last_cnt && en[c]));

        always_comb begin
            // NOTE: every output of this block is given a default first so no latch is inferred.
            state_d = state_q;
            cnt_d   = cnt_q;
            ps_d    = ps_q;
            hs_d    = hs_q;
            clk_d   = 1'b0;
            tick_d  = 1'b0;
            if (restart) begin
                state_d = ST_RUN;
                cnt_d   = '0;
                ps_d    = p_eff;
                hs_d    = h_eff;
                clk_d   = 1'b1;
                tick_d  = 1'b1;
            end else if (state_q == ST_RUN) begin
                if (last_cnt) begin
                    // Period finished with en low: stop cleanly, never a partial period.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    clk_d = (cnt_inc < hs_q);
                end
            end
        end

        // NOTE: state registers use non-blocking assignments so all flops update together.
        always_ff @(posedge CLOCK_50 or negedge reset) begin
            if (!reset) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                ps_q    <= DIV_W'(2);
                hs_q    <= DIV_W'(1);
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                ps_q    <= ps_d;
                hs_q    <= hs_d;
                clk_q   <= clk_d;
                tick_q  <= tick_d;
            end
        end

        assign clk_out[c] = clk_q;
        assign tick[c]    = tick_q;
        assign active[c]  = (state_q == ST_RUN);
    end

endmodule

// File: tb/tb_multi_clock_gen.sv
// Directed self-checking bench for multi_clock_gen: divide, duty clamps, glitch-free update,
// graceful disable, sync alignment and asynchronous reset.
module tb_multi_clock_gen;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 12;

    logic                    CLOCK_50 = 1'b0;
    logic                    reset    = 1'b0;
    logic [NUM_CH-1:0]       en       = '0;
    logic                    sync     = 1'b0;
    logic [NUM_CH*DIV_W-1:0] period   = '0;
    logic [NUM_CH*DIV_W-1:0] high     = '0;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       active;

    int checks   = 0;
    int failures = 0;

    multi_clock_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .en       (en),
        .sync     (sync),
        .period   (period),
        .high     (high),
        .clk_out  (clk_out),
        .tick     (tick),
        .active   (active)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic set_cfg(input int ch, input int p, input int h);
        period[ch*DIV_W +: DIV_W] = DIV_W'(p);
        high[ch*DIV_W +: DIV_W]   = DIV_W'(h);
    endtask

    // Expected waveform: high for hi cycles, low for per-hi, tick on count 0; k is the period count.
    task automatic expect_ch(input int ch, input int hi, input int per, input int k0, input int n,
                             input string tag);
        for (int k = k0; k < k0 + n; k++) begin
            check($sformatf("%s ch%0d clk k=%0d", tag, ch, k), 32'(clk_out[ch]), 32'((k % per) < hi));
            check($sformatf("%s ch%0d tick k=%0d", tag, ch, k), 32'(tick[ch]), 32'((k % per) == 0));
            check($sformatf("%s ch%0d active k=%0d", tag, ch, k), 32'(active[ch]), 32'd1);
            @(negedge CLOCK_50);
        end
    endtask

    task automatic expect_both(input int hi0, input int per0, input int hi1, input int per1,
                               input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s ch0 clk k=%0d", tag, k), 32'(clk_out[0]), 32'((k % per0) < hi0));
            check($sformatf("%s ch0 tick k=%0d", tag, k), 32'(tick[0]), 32'((k % per0) == 0));
            check($sformatf("%s ch1 clk k=%0d", tag, k), 32'(clk_out[1]), 32'((k % per1) < hi1));
            check($sformatf("%s ch1 tick k=%0d", tag, k), 32'(tick[1]), 32'((k % per1) == 0));
            @(negedge CLOCK_50);
        end
    endtask

    task automatic expect_idle(input int ch, input string tag);
        check($sformatf("%s ch%0d clk", tag, ch), 32'(clk_out[ch]), 32'd0);
        check($sformatf("%s ch%0d tick", tag, ch), 32'(tick[ch]), 32'd0);
        check($sformatf("%s ch%0d active", tag, ch), 32'(active[ch]), 32'd0);
    endtask

    // Start a channel, run nper full periods, drop en at a period start, expect one more period then idle.
    task automatic run_std(input int ch, input int p, input int h, input int hi, input int per,
                           input int nper, input string tag);
        set_cfg(ch, p, h);
        en[ch] = 1'b1;
        @(negedge CLOCK_50);
        expect_ch(ch, hi, per, 0, nper * per, tag);
        en[ch] = 1'b0;
        expect_ch(ch, hi, per, 0, per, {tag, "_stop"});
        expect_idle(ch, {tag, "_idle"});
    endtask

    initial begin
        repeat (2) @(negedge CLOCK_50);
        expect_idle(0, "in_reset");
        expect_idle(1, "in_reset");
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        expect_idle(0, "post_reset");
        expect_idle(1, "post_reset");

        run_std(0, 10, 0, 5, 10, 3, "basic");
        run_std(0, 7, 2, 2, 7, 3, "duty7_2");
        run_std(0, 1, 0, 1, 2, 4, "period1");
        run_std(0, 4, 9, 3, 4, 3, "clamp4_9");
        run_std(1, 5, 0, 2, 5, 2, "ch1_5");

        // Mid-period period change: current 10-cycle period completes, then 4-cycle periods.
        set_cfg(0, 10, 0);
        en[0] = 1'b1;
        @(negedge CLOCK_50);
        expect_ch(0, 5, 10, 0, 3, "upd_a");
        set_cfg(0, 4, 0);
        expect_ch(0, 5, 10, 3, 7, "upd_b");
        expect_ch(0, 2, 4, 0, 12, "upd_c");
        en[0] = 1'b0;
        expect_ch(0, 2, 4, 0, 4, "upd_stop");
        expect_idle(0, "upd_idle");

        // Graceful disable with a re-enable in the last cycle, then a real disable.
        set_cfg(0, 8, 0);
        en[0] = 1'b1;
        @(negedge CLOCK_50);
        expect_ch(0, 4, 8, 0, 2, "dis_a");
        en[0] = 1'b0;
        expect_ch(0, 4, 8, 2, 5, "dis_b");
        en[0] = 1'b1;
        expect_ch(0, 4, 8, 7, 1, "dis_c");
        expect_ch(0, 4, 8, 0, 10, "dis_seam");
        en[0] = 1'b0;
        expect_ch(0, 4, 8, 2, 6, "dis_d");
        expect_idle(0, "dis_idle");

        // Sync alignment of two channels with different periods.
        set_cfg(0, 6, 0);
        set_cfg(1, 9, 0);
        en[0] = 1'b1;
        @(negedge CLOCK_50);
        expect_ch(0, 3, 6, 0, 2, "sync_pre");
        en[1] = 1'b1;
        @(negedge CLOCK_50);
        check("sync_pre ch0 tick", 32'(tick[0]), 32'd0);
        check("sync_pre ch1 tick", 32'(tick[1]), 32'd1);
        sync = 1'b1;
        @(negedge CLOCK_50);
        sync = 1'b0;
        expect_both(3, 6, 4, 9, 18, "sync");
        en = '0;
        repeat (6) @(negedge CLOCK_50);
        expect_idle(0, "sync_stop");
        check("sync_stop ch1 active", 32'(active[1]), 32'd1);
        repeat (3) @(negedge CLOCK_50);
        expect_idle(1, "sync_stop");

        // Sync on idle channels with en low does nothing.
        sync = 1'b1;
        @(negedge CLOCK_50);
        sync = 1'b0;
        expect_idle(0, "sync_idle");
        expect_idle(1, "sync_idle");
        @(negedge CLOCK_50);
        expect_idle(0, "sync_idle2");

        // Asynchronous reset while clk_out0 is high, restart with new config after release.
        set_cfg(0, 5, 0);
        en[0] = 1'b1;
        @(negedge CLOCK_50);
        check("ar_pre clk", 32'(clk_out[0]), 32'd1);
        #2 reset = 1'b0;
        #1;
        expect_idle(0, "ar_async");
        set_cfg(0, 3, 0);
        repeat (2) @(negedge CLOCK_50);
        expect_idle(0, "ar_hold");
        reset = 1'b1;
        @(negedge CLOCK_50);
        expect_ch(0, 1, 3, 0, 9, "ar_restart");
        en[0] = 1'b0;
        expect_ch(0, 1, 3, 0, 3, "ar_stop");
        expect_idle(0, "ar_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
